// File: rtl/tx_pause_gate.sv
// tx_pause_gate
// Frame-aware 802.3x pause gate in the TX AXI-Stream path, ahead of the
// AXIS-to-XGMII encoder. While the link partner requests a pause, no new
// frame is allowed to start; a frame already in flight always completes.
// A single output register stage carries the beats downstream, and two
// saturating counters record how often and how long transmission was paused.
module tx_pause_gate #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              aresetn,

    input  logic              cfg_tx_pause_enable,
    input  logic              rx_pause_active,

    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic              s_axis_tready,

    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    input  logic              m_axis_tready,

    output logic              tx_paused,
    output logic [STAT_W-1:0] stat_pause_events,
    output logic [STAT_W-1:0] stat_pause_cycles
);

    // S_IDLE   : between frames; the next accepted beat is a start of frame.
    // S_FRAME  : inside a frame; the gate stays open until tlast is accepted.
    // S_PAUSED : partner pause honoured; no new frame may start.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FRAME  = 2'd1,
        S_PAUSED = 2'd2
    } state_e;

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    state_e            state_q, state_d;

    logic              pause_req;
    logic              gate_open;
    logic              out_free;
    logic              accept;
    logic              enter_pause;

    logic [DATA_W-1:0] data_q, data_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              user_q, user_d;

    logic [STAT_W-1:0] events_q, events_d;
    logic [STAT_W-1:0] cycles_q, cycles_d;

    // Counter step that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // The pause only matters when the feature is enabled.
    assign pause_req = rx_pause_active & cfg_tx_pause_enable;

    // The output register can take a beat when it is empty or being drained
    // this cycle; the gate never blocks the drain side.
    assign out_free      = !valid_q | m_axis_tready;
    assign s_axis_tready = gate_open & out_free;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: pause can only take effect at a frame boundary.
    // NOTE: state_d is given a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pause_req) begin
                    state_d = S_PAUSED;
                end else if (accept && !s_axis_tlast) begin
                    state_d = S_FRAME;
                end
            end
            S_FRAME: begin
                if (accept && s_axis_tlast) begin
                    state_d = pause_req ? S_PAUSED : S_IDLE;
                end
            end
            S_PAUSED: begin
                if (!pause_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: gate state and pause indication per state.
    always_comb begin
        gate_open = 1'b0;
        tx_paused = 1'b0;
        unique case (state_q)
            S_IDLE:   gate_open = !pause_req;
            S_FRAME:  gate_open = 1'b1;
            S_PAUSED: tx_paused = 1'b1;
            default: begin
                gate_open = 1'b0;
                tx_paused = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    // Load on accept, otherwise hold; valid drops once the beat is taken.
    always_comb begin
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        user_d  = user_q;
        valid_d = valid_q;
        if (accept) begin
            data_d  = s_axis_tdata;
            keep_d  = s_axis_tkeep;
            last_d  = s_axis_tlast;
            user_d  = s_axis_tuser;
            valid_d = 1'b1;
        end else if (m_axis_tready) begin
            valid_d = 1'b0;
        end
    end

    // Output register; payload flops are cleared on reset so the bus
    // presents a known all-zero beat while held in reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            user_q  <= user_d;
            valid_q <= valid_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tvalid = valid_q;

    // ------------------------------------------------------------------
    // Pause statistics
    // ------------------------------------------------------------------
    // An entry is any transition from a non-paused state into S_PAUSED.
    assign enter_pause = (state_q != S_PAUSED) && (state_d == S_PAUSED);

    // Saturating next values for the event and residency counters.
    always_comb begin
        events_d = events_q;
        cycles_d = cycles_q;
        if (enter_pause) begin
            events_d = sat_inc(events_q);
        end
        if (state_q == S_PAUSED) begin
            cycles_d = sat_inc(cycles_q);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            events_q <= '0;
            cycles_q <= '0;
        end else begin
            events_q <= events_d;
            cycles_q <= cycles_d;
        end
    end

    assign stat_pause_events = events_q;
    assign stat_pause_cycles = cycles_q;

endmodule

// File: tb/tb_tx_pause_gate.sv
// tb_tx_pause_gate
// Scoreboard bench for tx_pause_gate: accepted input beats are queued with
// their acceptance cycle and compared in order against the output stream.
// A second instance with 4-bit counters exercises statistics saturation.
module tb_tx_pause_gate;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int STAT_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic              user;
    } beat_t;

    typedef struct {
        beat_t b;
        int    cyc;
    } sb_t;

    logic              clk = 1'b0;
    logic              aresetn;
    logic              cfg_en;
    logic              rx_pause;
    logic [DATA_W-1:0] s_data;
    logic [KEEP_W-1:0] s_keep;
    logic              s_valid;
    logic              s_last;
    logic              s_user;
    logic              s_tready;
    logic [DATA_W-1:0] m_data;
    logic [KEEP_W-1:0] m_keep;
    logic              m_valid;
    logic              m_last;
    logic              m_user;
    logic              m_tready;
    logic              tx_paused;
    logic [STAT_W-1:0] events;
    logic [STAT_W-1:0] pcycles;

    logic              d4_s_tready;
    logic [DATA_W-1:0] d4_m_data;
    logic [KEEP_W-1:0] d4_m_keep;
    logic              d4_m_valid;
    logic              d4_m_last;
    logic              d4_m_user;
    logic              d4_tx_paused;
    logic [3:0]        d4_events;
    logic [3:0]        d4_pcycles;

    sb_t   sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    logic  chk_lat   = 1'b0;
    logic  chk_split = 1'b0;
    logic  in_frame  = 1'b0;
    logic  prev_stall = 1'b0;
    beat_t prev_out;
    bit    done = 1'b0;

    beat_t out_beat;
    beat_t in_beat;
    assign out_beat = {m_data, m_keep, m_last, m_user};
    assign in_beat  = {s_data, s_keep, s_last, s_user};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    tx_pause_gate #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .STAT_W(STAT_W)) dut (
        .clk                 (clk),
        .aresetn             (aresetn),
        .cfg_tx_pause_enable (cfg_en),
        .rx_pause_active     (rx_pause),
        .s_axis_tdata        (s_data),
        .s_axis_tkeep        (s_keep),
        .s_axis_tvalid       (s_valid),
        .s_axis_tlast        (s_last),
        .s_axis_tuser        (s_user),
        .s_axis_tready       (s_tready),
        .m_axis_tdata        (m_data),
        .m_axis_tkeep        (m_keep),
        .m_axis_tvalid       (m_valid),
        .m_axis_tlast        (m_last),
        .m_axis_tuser        (m_user),
        .m_axis_tready       (m_tready),
        .tx_paused           (tx_paused),
        .stat_pause_events   (events),
        .stat_pause_cycles   (pcycles)
    );

    tx_pause_gate #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .STAT_W(4)) dut4 (
        .clk                 (clk),
        .aresetn             (aresetn),
        .cfg_tx_pause_enable (cfg_en),
        .rx_pause_active     (rx_pause),
        .s_axis_tdata        (s_data),
        .s_axis_tkeep        (s_keep),
        .s_axis_tvalid       (s_valid),
        .s_axis_tlast        (s_last),
        .s_axis_tuser        (s_user),
        .s_axis_tready       (d4_s_tready),
        .m_axis_tdata        (d4_m_data),
        .m_axis_tkeep        (d4_m_keep),
        .m_axis_tvalid       (d4_m_valid),
        .m_axis_tlast        (d4_m_last),
        .m_axis_tuser        (d4_m_user),
        .m_axis_tready       (m_tready),
        .tx_paused           (d4_tx_paused),
        .stat_pause_events   (d4_events),
        .stat_pause_cycles   (d4_pcycles)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        sb_t e;
        if (!aresetn) begin
            sb_q.delete();
            in_frame   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (m_valid && prev_stall)
                check("hold_stable", 128'(out_beat), 128'(prev_out));
            if (m_valid && m_tready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("beat", 128'(out_beat), 128'(e.b));
                    if (chk_lat)
                        check("latency", 128'(cyc - e.cyc), 128'(1));
                end
            end
            prev_stall = m_valid && !m_tready;
            prev_out   = out_beat;
            if (s_valid && s_tready) begin
                e.b   = in_beat;
                e.cyc = cyc;
                sb_q.push_back(e);
                in_frame = !s_last;
            end
            if (chk_split && tx_paused)
                check("no_split", 128'(in_frame), 128'(0));
        end
    end

    function automatic beat_t mk_beat(input int fid, input int i, input int n);
        beat_t b;
        b.data = {fid[15:0], i[15:0], 32'($urandom())};
        b.keep = (i == n - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
        b.last = (i == n - 1);
        b.user = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic put(input beat_t b);
        s_data  = b.data;
        s_keep  = b.keep;
        s_last  = b.last;
        s_user  = b.user;
        s_valid = 1'b1;
    endtask

    // Present a beat and hold it until accepted; returns stalled cycles.
    task automatic drive_beat(input beat_t b, output int waits);
        logic rdy;
        int   w = 0;
        put(b);
        do begin
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            #1;
            if (!rdy) w++;
        end while (!rdy && w < 300);
        if (!rdy) check("accept_timeout", 128'(0), 128'(1));
        waits = w;
    endtask

    task automatic send_frame(input int n, input int fid, output int waits);
        int w;
        waits = 0;
        for (int i = 0; i < n; i++) begin
            drive_beat(mk_beat(fid, i, n), w);
            waits += w;
        end
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        aresetn  = 1'b1;
        cfg_en   = 1'b1;
        rx_pause = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_keep   = '0;
        s_last   = 1'b0;
        s_user   = 1'b0;
        m_tready = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        check("rst_valid",  128'(m_valid),   128'(0));
        check("rst_paused", 128'(tx_paused), 128'(0));
        check("rst_events", 128'(events),    128'(0));
        check("rst_cycles", 128'(pcycles),   128'(0));
        check("rst_data",   128'(m_data),    128'(0));
        @(posedge clk);
        #1 aresetn = 1'b1;
        idle(2);

        // 1: plain pass-through, fixed one-cycle latency, no stalls.
        chk_lat = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_frame(4, f, w);
            check("t1_no_wait", 128'(w), 128'(0));
        end
        idle(3);
        chk_lat = 1'b0;
        check("t1_drained", 128'(sb_q.size()), 128'(0));
        check("t1_events",  128'(events),      128'(0));
        check("t1_cycles",  128'(pcycles),     128'(0));

        // 2: pause rises on beat 2 of 8; held 20 cycles from the rise.
        for (int i = 0; i < 8; i++) begin
            put(mk_beat(10, i, 8));
            if (i == 1) rx_pause = 1'b1;
            @(negedge clk);
            check("t2_inframe_ready", 128'(s_tready), 128'(1));
            @(posedge clk);
            #1;
        end
        put(mk_beat(11, 0, 2));
        for (int j = 0; j < 13; j++) begin
            @(negedge clk);
            check("t2_sop_held", 128'(s_tready),  128'(0));
            check("t2_paused",   128'(tx_paused), 128'(1));
            @(posedge clk);
            #1;
        end
        rx_pause = 1'b0;
        @(negedge clk);
        check("t2_release_cycle", 128'(s_tready), 128'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t2_sop_ready", 128'(s_tready),  128'(1));
        check("t2_unpaused",  128'(tx_paused), 128'(0));
        check("t2_events",    128'(events),    128'(1));
        check("t2_cycles",    128'(pcycles),   128'(14));
        @(posedge clk);
        #1;
        drive_beat(mk_beat(11, 1, 2), w);
        s_valid = 1'b0;
        idle(3);

        // 3: pause rises in the same cycle as the tlast accept.
        for (int i = 0; i < 3; i++) begin
            put(mk_beat(12, i, 3));
            if (i == 2) rx_pause = 1'b1;
            @(negedge clk);
            check("t3_inframe_ready", 128'(s_tready), 128'(1));
            @(posedge clk);
            #1;
        end
        put(mk_beat(13, 0, 1));
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("t3_sop_held", 128'(s_tready),  128'(0));
            check("t3_paused",   128'(tx_paused), 128'(1));
            @(posedge clk);
            #1;
        end
        rx_pause = 1'b0;
        @(negedge clk);
        check("t3_release_cycle", 128'(s_tready), 128'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_sop_ready", 128'(s_tready), 128'(1));
        check("t3_events",    128'(events),   128'(2));
        check("t3_cycles",    128'(pcycles),  128'(18));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        idle(3);

        // 4: pause ignored when disabled; disabling mid-pause releases.
        cfg_en   = 1'b0;
        rx_pause = 1'b1;
        send_frame(3, 14, w);
        check("t4_no_wait", 128'(w), 128'(0));
        send_frame(1, 15, w);
        check("t4_no_wait_1beat", 128'(w), 128'(0));
        @(negedge clk);
        check("t4_not_paused", 128'(tx_paused), 128'(0));
        check("t4_events",     128'(events),    128'(2));
        check("t4_cycles",     128'(pcycles),   128'(18));
        @(posedge clk);
        #1;
        cfg_en = 1'b1;
        @(negedge clk);
        check("t4_gate_closed", 128'(s_tready), 128'(0));
        @(posedge clk);
        #1;
        put(mk_beat(16, 0, 1));
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("t4_paused", 128'(tx_paused), 128'(1));
            check("t4_held",   128'(s_tready),  128'(0));
            @(posedge clk);
            #1;
        end
        cfg_en = 1'b0;
        @(negedge clk);
        check("t4_drop_cycle", 128'(s_tready), 128'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_released",   128'(s_tready),   128'(1));
        check("t4_unpaused",   128'(tx_paused),  128'(0));
        check("t4_events2",    128'(events),     128'(3));
        check("t4_cycles2",    128'(pcycles),    128'(21));
        check("t4_d4_cyc_sat", 128'(d4_pcycles), 128'(15));
        @(posedge clk);
        #1;
        s_valid  = 1'b0;
        rx_pause = 1'b0;
        cfg_en   = 1'b1;
        idle(3);

        // 5: random backpressure with pause toggling every 37 cycles.
        chk_split = 1'b1;
        done      = 1'b0;
        fork
            begin
                int ww;
                for (int f = 0; f < 30; f++) begin
                    send_frame($urandom_range(1, 6), 100 + f, ww);
                    idle($urandom_range(0, 2));
                end
                done = 1'b1;
            end
            begin
                int cnt = 0;
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_tready = 1'($urandom_range(0, 1));
                    if (cnt % 37 == 36) rx_pause = !rx_pause;
                    cnt++;
                end
            end
        join
        rx_pause = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 50 && (sb_q.size() != 0 || m_valid); k++)
            @(negedge clk);
        check("t5_drained", 128'(sb_q.size()), 128'(0));
        chk_split = 1'b0;
        @(posedge clk);
        #1;

        // 6: clear stats, 20 single-cycle pulses, then reset mid-frame.
        aresetn = 1'b0;
        @(posedge clk);
        #1 aresetn = 1'b1;
        check("t6_events_clr", 128'(events), 128'(0));
        for (int p = 0; p < 20; p++) begin
            rx_pause = 1'b1;
            @(posedge clk);
            #1;
            rx_pause = 1'b0;
            @(negedge clk);
            check("t6_pulse_paused", 128'(tx_paused), 128'(1));
            @(posedge clk);
            #1;
            @(negedge clk);
            check("t6_pulse_released", 128'(tx_paused), 128'(0));
            @(posedge clk);
            #1;
        end
        check("t6_events",    128'(events),     128'(20));
        check("t6_cycles",    128'(pcycles),    128'(20));
        check("t6_d4_events", 128'(d4_events),  128'(15));
        check("t6_d4_cycles", 128'(d4_pcycles), 128'(15));

        drive_beat(mk_beat(20, 0, 4), w);
        drive_beat(mk_beat(20, 1, 4), w);
        put(mk_beat(20, 2, 4));
        #2;
        aresetn = 1'b0;
        s_valid = 1'b0;
        #1;
        check("t6_rst_valid",  128'(m_valid),   128'(0));
        check("t6_rst_data",   128'(m_data),    128'(0));
        check("t6_rst_keep",   128'(m_keep),    128'(0));
        check("t6_rst_last",   128'(m_last),    128'(0));
        check("t6_rst_user",   128'(m_user),    128'(0));
        check("t6_rst_paused", 128'(tx_paused), 128'(0));
        check("t6_rst_events", 128'(events),    128'(0));
        check("t6_rst_cycles", 128'(pcycles),   128'(0));
        check("t6_rst_d4_ev",  128'(d4_events), 128'(0));
        @(posedge clk);
        #1 aresetn = 1'b1;
        send_frame(2, 21, w);
        check("t6_recover_no_wait", 128'(w), 128'(0));
        idle(3);
        check("t6_drained", 128'(sb_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
